if_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register for the MIPS 5-stage pipelined CPU.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds a fetched word while the pipeline stalls and discards wrong-path fetches on redirect.
- Presents `inst_id`, `pc_id` and `pc4_id` to the decode/controller stage.
- Obeys `if_en`, `if_rst`, `id_en` and `id_rst` from the pipeline controller.

---
 rtl/if_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC, talks req/ack to instruction memory, and holds or drops words on stall/redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rst,
  input  logic        if_en,
  input  logic        id_rst,
  input  logic        id_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc4_id,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] inst_id_q, inst_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        id_valid_q, id_valid_d;

  logic        redir;
  logic [31:0] redir_tgt;
  logic        avail;
  logic        transfer;
  logic [31:0] if_word;

  // if_rst behaves exactly like a redirect to RESET_PC, and wins over a real redirect.
  assign redir     = if_rst | redirect_valid;
  assign redir_tgt = if_rst ? (RESET_PC & ~32'h3) : (redirect_pc & ~32'h3);

  assign avail     = ((state_q == S_FETCH) & imem_ack) | (state_q == S_HOLD);
  assign if_valid  = avail & ~redir;
  assign transfer  = if_valid & if_en;
  assign if_word   = (state_q == S_HOLD) ? hold_inst_q : imem_rdata;

  assign imem_req  = ~rst & (state_q != S_HOLD);
  assign imem_addr = fetch_pc_q;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    hold_inst_d  = hold_inst_q;

    unique case (state_q)
      S_FETCH: begin
        if (redir) begin
          if (imem_ack) begin
            fetch_pc_d = redir_tgt;
          end else begin
            pending_pc_d = redir_tgt;
            state_d      = S_DROP;
          end
        end else if (transfer) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (imem_ack) begin
          // fetch_pc stays put while holding, so it doubles as the held word's PC.
          hold_inst_d = imem_rdata;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir) begin
          fetch_pc_d = redir_tgt;
          state_d    = S_FETCH;
        end else if (transfer) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        if (redir) pending_pc_d = redir_tgt;
        if (imem_ack) begin
          fetch_pc_d = pending_pc_d;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    inst_id_d  = inst_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    id_valid_d = id_valid_q;

    if (id_rst) begin
      inst_id_d  = NOP_INST;
      id_valid_d = 1'b0;
    end else if (id_en) begin
      if (transfer) begin
        inst_id_d  = if_word;
        pc_id_d    = fetch_pc_q;
        pc4_id_d   = fetch_pc_q + 32'd4;
        id_valid_d = 1'b1;
      end else begin
        inst_id_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC & ~32'h3;
      pending_pc_q <= RESET_PC & ~32'h3;
      hold_inst_q  <= NOP_INST;
      inst_id_q    <= NOP_INST;
      pc_id_q      <= 32'h0000_0000;
      pc4_id_q     <= 32'h0000_0004;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      hold_inst_q  <= hold_inst_d;
      inst_id_q    <= inst_id_d;
      pc_id_q      <= pc_id_d;
      pc4_id_q     <= pc4_id_d;
      id_valid_q   <= id_valid_d;
    end
  end

  assign inst_id  = inst_id_q;
  assign pc_id    = pc_id_q;
  assign pc4_id   = pc4_id_q;
  assign id_valid = id_valid_q;

endmodule
